mux_pipe: RTL and testbench

MUX_PIPE -- requirements
Module: mux_pipe

---
 rtl/mux_pkg.sv | 10 +
 rtl/mux_skid_buf.sv | 66 ++++++
 rtl/mux_pipe.sv | 57 +++++
 tb/tb_mux_pipe.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the pipelined channel multiplexer.
package mux_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b10
   } skid_state_t;

endpackage

// File: rtl/mux_skid_buf.sv
// Two-entry skid buffer: registered handshake, order-preserving, one transfer per cycle.
module mux_skid_buf
   import mux_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] data_out,
   output logic         out_valid,
   input  logic         out_ready
);

   skid_state_t  state;
   logic [N-1:0] skid;

   // in_ready and out_valid are flops updated alongside state, so neither
   // depends combinationally on the handshake inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         data_out  <= '0;
         skid      <= '0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (in_valid) begin
                  data_out  <= in_data;
                  state     <= ONE;
                  out_valid <= 1'b1;
               end
            end
            ONE: begin
               if (in_valid && out_ready) begin
                  data_out <= in_data;
               end else if (in_valid) begin
                  skid     <= in_data;
                  state    <= TWO;
                  in_ready <= 1'b0;
               end else if (out_ready) begin
                  state     <= EMPTY;
                  out_valid <= 1'b0;
               end
            end
            TWO: begin
               if (out_ready) begin
                  data_out <= skid;
                  state    <= ONE;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state     <= EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/mux_pipe.sv
// Channel select with range check feeding a two-entry skid buffer; sticky sel_err.
module mux_pipe
   import mux_pkg::*;
#(
   parameter int unsigned  N      = 32,
   parameter int unsigned  NUM_IN = 4,
   localparam int unsigned SEL_W  = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_IN*N-1:0] data_in,
   input  logic [SEL_W-1:0]    sel,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [N-1:0]        data_out,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                sel_err
);

   logic [N-1:0] sel_data;
   logic         in_range;

   // Out-of-range selects match no channel and so fall through to zero data.
   always_comb begin
      sel_data = '0;
      in_range = 1'b0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         if (32'(sel) == k) begin
            sel_data = data_in[k*N +: N];
            in_range = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_err <= 1'b0;
      end else if (in_valid && in_ready && !in_range) begin
         sel_err <= 1'b1;
      end
   end

   mux_skid_buf #(
      .N (N)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_data   (sel_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_out  (data_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

endmodule

// File: tb/tb_mux_pipe.sv
// Directed and randomized-handshake checks of mux_pipe with 4 and 3 channels.
module tb_mux_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [127:0] data_in4;
   logic [1:0]   sel4;
   logic         iv4, ir4, ov4, or4, err4;
   logic [31:0]  do4;

   logic [95:0]  data_in3;
   logic [1:0]   sel3;
   logic         iv3, ir3, ov3, or3, err3;
   logic [31:0]  do3;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   mux_pipe #(.N(32), .NUM_IN(4)) dut4 (
      .clk(clk), .rst(rst), .data_in(data_in4), .sel(sel4), .in_valid(iv4),
      .in_ready(ir4), .data_out(do4), .out_valid(ov4), .out_ready(or4), .sel_err(err4)
   );

   mux_pipe #(.N(32), .NUM_IN(3)) dut3 (
      .clk(clk), .rst(rst), .data_in(data_in3), .sel(sel3), .in_valid(iv3),
      .in_ready(ir3), .data_out(do3), .out_valid(ov3), .out_ready(or3), .sel_err(err3)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] q[$];
   logic [31:0] held, exp_word;
   logic        acc, drn, hold;

   initial begin
      data_in4 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      data_in3 = {32'hB2, 32'hB1, 32'hB0};
      sel4 = '0; iv4 = 0; or4 = 0;
      sel3 = '0; iv3 = 0; or3 = 0;

      // Reset state
      rst = 1;
      step();
      check("rst_ov", 64'(ov4), 64'd0);
      check("rst_do", 64'(do4), 64'd0);
      check("rst_err", 64'(err4), 64'd0);
      rst = 0;
      step();
      check("rst_ir", 64'(ir4), 64'd1);

      // Single transfer, latency 1
      sel4 = 2; iv4 = 1; or4 = 1;
      step();
      iv4 = 0;
      check("single_ov", 64'(ov4), 64'd1);
      check("single_do", 64'(do4), 64'hA2);
      step();
      check("single_ov_drop", 64'(ov4), 64'd0);

      // Backpressure: fill to TWO, third offer held off
      or4 = 0; iv4 = 1; sel4 = 0;
      check("bp_ir0", 64'(ir4), 64'd1);
      step();
      sel4 = 1;
      check("bp_ir1", 64'(ir4), 64'd1);
      step();
      sel4 = 3;
      check("bp_ir2", 64'(ir4), 64'd0);
      check("bp_head", 64'(do4), 64'hA0);
      step();
      check("bp_hold_ir", 64'(ir4), 64'd0);
      check("bp_hold_do", 64'(do4), 64'hA0);
      or4 = 1;
      step();
      check("bp_out1", 64'(do4), 64'hA1);
      check("bp_ir_back", 64'(ir4), 64'd1);
      step();
      iv4 = 0;
      check("bp_out2", 64'(do4), 64'hA3);
      check("bp_out2_ov", 64'(ov4), 64'd1);
      step();
      check("bp_empty", 64'(ov4), 64'd0);

      // Streaming at one transfer per cycle
      iv4 = 1; or4 = 1;
      for (int i = 0; i < 8; i++) begin
         sel4 = 2'(i % 4);
         check("stream_ir", 64'(ir4), 64'd1);
         step();
         check("stream_ov", 64'(ov4), 64'd1);
         check("stream_do", 64'(do4), 64'(32'hA0 + 32'(i % 4)));
      end
      iv4 = 0;
      step();
      check("stream_end", 64'(ov4), 64'd0);

      // Out-of-range select on the 3-channel instance
      sel3 = 3; iv3 = 1; or3 = 1;
      step();
      check("oor_do", 64'(do3), 64'd0);
      check("oor_ov", 64'(ov3), 64'd1);
      check("oor_err", 64'(err3), 64'd1);
      sel3 = 1;
      step();
      iv3 = 0;
      check("oor_next_do", 64'(do3), 64'hB1);
      check("oor_sticky", 64'(err3), 64'd1);
      step();
      check("oor_sticky2", 64'(err3), 64'd1);
      check("oor_empty", 64'(ov3), 64'd0);

      // Reset while full discards held entries
      or4 = 0; iv4 = 1; sel4 = 1;
      step();
      sel4 = 2;
      step();
      iv4 = 0;
      check("full_ir", 64'(ir4), 64'd0);
      rst = 1;
      step();
      rst = 0;
      check("mid_rst_ov", 64'(ov4), 64'd0);
      check("mid_rst_err", 64'(err3), 64'd0);
      check("mid_rst_ir", 64'(ir4), 64'd1);
      or4 = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("no_stale", 64'(ov4), 64'd0);
      end
      sel4 = 3; iv4 = 1;
      step();
      iv4 = 0;
      check("post_rst_do", 64'(do4), 64'hA3);
      step();

      // Random handshake against a queue scoreboard
      for (int c = 0; c < 1000; c++) begin
         data_in4 = {$urandom, $urandom, $urandom, $urandom};
         sel4 = 2'($urandom_range(0, 3));
         iv4 = 1'($urandom_range(0, 1));
         or4 = 1'($urandom_range(0, 1));
         check("rnd_ov", 64'(ov4), 64'(q.size() != 0));
         check("rnd_ir", 64'(ir4), 64'(q.size() < 2));
         acc  = iv4 && (q.size() < 2);
         drn  = or4 && (q.size() != 0);
         hold = (q.size() != 0) && !or4;
         held = do4;
         if (drn) begin
            exp_word = q.pop_front();
            check("rnd_data", 64'(do4), 64'(exp_word));
         end
         if (acc) q.push_back(data_in4[32*sel4 +: 32]);
         step();
         if (hold) begin
            check("rnd_stable_ov", 64'(ov4), 64'd1);
            check("rnd_stable_do", 64'(do4), 64'(held));
         end
      end
      iv4 = 0; or4 = 1;
      for (int c = 0; c < 3; c++) begin
         if (q.size() != 0) begin
            exp_word = q.pop_front();
            check("rnd_drain", 64'(do4), 64'(exp_word));
         end
         step();
      end
      check("rnd_final_ov", 64'(ov4), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
